quote_egress_scheduler: RTL and testbench
=========================================

// Module: quote_egress_scheduler
// PURPOSE
//  Multi-stock quote egress stage between trading_logic/order_quantity and the wire-format encoder.
//  Holds one latest-quote slot per stock; newer quotes for the same stock coalesce (overwrite).
//  Round-robin arbitrates eligible stocks and serialises each quote as a buy beat then a sell beat.
//  Output uses a valid/ready handshake; a per-stock minimum re-quote gap throttles each stock.
// PARAMETERS
//  NUM_STOCKS    4   number of stock channels/slots (>=2)
//  DATA_WIDTH   32   price width
//  QTY_WIDTH    32   order quantity width
//  FP_WORD_SIZE 64   timestamp width
//  MIN_GAP      16   cycles a stock is ineligible after its sell beat completes (0 = no throttle)
//  SID_W  $clog2(NUM_STOCKS), derived, not overridable
// PORTS
//  i_clk            in   1             clock
//  i_reset_n        in   1             async active-low reset
//  i_quote_valid    in   1             quote strobe, one cycle per quote
//  i_stock_id       in   SID_W         stock of incoming quote
//  i_buy_price      in   DATA_WIDTH    bid to post; 0 = no buy side
//  i_sell_price     in   DATA_WIDTH    ask to post; 0 = no sell side
//  i_quantity       in   QTY_WIDTH     quantity for both sides
//  i_timestamp      in   FP_WORD_SIZE  quote timestamp
//  i_flush          in   1             clear all pending slots
//  i_ready          in   1             downstream accepts current beat
//  o_valid          out  1             beat valid
//  o_side           out  1             0 = buy, 1 = sell
//  o_stock_id       out  SID_W         stock of beat
//  o_price          out  DATA_WIDTH    beat price
//  o_quantity       out  QTY_WIDTH     beat quantity
//  o_timestamp      out  FP_WORD_SIZE  beat timestamp
//  o_coalesce_cnt   out  16            saturating count of overwritten pending quotes
//  o_busy           out  1             any slot pending or FSM not IDLE
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, slots empty, gap counters 0, FSM IDLE, RR pointer 0.
//  Slot write: on i_quote_valid, slot[i_stock_id] <= {buy,sell,qty,ts}, pending set.
//   - Both prices 0: quote dropped, slot untouched.
//   - Slot already pending: overwrite; o_coalesce_cnt +1, saturates at 16'hFFFF.
//  Eligible(s) = pending[s] && gap[s]==0. Gap counters decrement by 1 per cycle, floor at 0.
//  FSM IDLE: if any eligible, grant the first eligible stock at or after rr_ptr+1 (wrapping).
//   Copy the slot to the holding register, clear its pending bit, rr_ptr <= granted stock.
//   Next state: BUY if buy!=0, else SELL.
//   A same-cycle write to the granted stock sets pending again; the new quote is kept.
//  BUY: o_valid=1, o_side=0, o_price=buy. On i_ready: next state SELL if sell!=0, else DONE.
//  SELL: o_valid=1, o_side=1, o_price=sell. On i_ready: next state DONE.
//  DONE (1 cycle): gap[stock] <= MIN_GAP; next state IDLE. o_valid=0 in IDLE and DONE.
//  Handshake: while o_valid && !i_ready, all o_* beat fields are held stable.
//   A beat transfers on o_valid && i_ready. o_valid never depends combinationally on i_ready.
//  Latency: quote at edge N -> slot at N -> IDLE grant at N+1 -> o_valid high after edge N+2.
//   Minimum pair period is 4 cycles (IDLE, BUY, SELL, DONE) with i_ready tied high.
//  i_flush: clears all pending bits that cycle and wins over a same-cycle i_quote_valid.
//   An in-flight pair completes (no beat is aborted). Gap counters are unaffected.
//  All outputs are registered. Quantity and timestamp are passed through unmodified.
// STRUCTURE
//  hft_pkg: egress_state_t enum {IDLE,BUY,SELL,DONE}; side_t enum {SIDE_BUY=0,SIDE_SELL=1};
//   quote_t packed struct {buy_price, sell_price, quantity, timestamp}.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr; outputs grant_id, grant_vld (combinational).
//  Slots, gap counters and FSM live in this module.
// TESTING
//  1 Reset; quote stk2 buy=100 sell=105 qty=10, ready=1 -> after edge N+2 a buy beat (stk2,100),
//    next cycle a sell beat (stk2,105), then o_valid=0.
//  2 Quotes for stk1 at cycles 0,1 (second buy=200) while blocked by ready=0 on another pair
//    -> only buy=200 is emitted for stk1; o_coalesce_cnt=1.
//  3 Stocks 0,1,3 pending together, ready=1, MIN_GAP=0 -> grant order 0,1,3, then 0 again
//    if stk0 was requoted.
//  4 MIN_GAP=16: stk0 requoted right after its sell beat -> next stk0 buy beat no earlier
//    than 16 cycles after DONE.
//  5 ready=0 for 5 cycles during buy beat -> o_* stable all 5 cycles; one transfer only.
//  6 buy=0 sell=50 -> only a sell beat. Both prices 0 -> no beat.
//    Reset asserted during SELL -> o_valid=0 immediately.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared types for the quote egress path: FSM states, beat side encoding and the
// default-width quote record.
package hft_pkg;

    localparam int HFT_DATA_W = 32;
    localparam int HFT_QTY_W  = 32;
    localparam int HFT_TS_W   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUY  = 2'd1,
        SELL = 2'd2,
        DONE = 2'd3
    } egress_state_t;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } side_t;

    typedef struct packed {
        logic [HFT_DATA_W-1:0] buy_price;
        logic [HFT_DATA_W-1:0] sell_price;
        logic [HFT_QTY_W-1:0]  quantity;
        logic [HFT_TS_W-1:0]   timestamp;
    } quote_t;

endpackage

// File: rtl/quote_egress_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// i_ptr, wrapping, so i_ptr itself has the lowest priority.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int SID_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SID_W-1:0] i_ptr,
    output logic [SID_W-1:0] o_grant_id,
    output logic             o_grant_vld
);

    logic [SID_W-1:0] w_idx;

    always_comb begin
        o_grant_id  = '0;
        o_grant_vld = 1'b0;
        w_idx       = '0;
        // Scan farthest-first so the nearest requester after i_ptr is the final writer.
        for (int k = N; k >= 1; k--) begin
            w_idx = SID_W'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_grant_vld = 1'b1;
                o_grant_id  = w_idx;
            end
        end
    end

endmodule

// File: rtl/quote_egress_scheduler.sv
// Quote egress scheduler: one coalescing quote slot per stock, round-robin grant,
// and buy/sell beat serialisation onto a valid/ready stream with per-stock throttling.
module quote_egress_scheduler
    import hft_pkg::*;
#(
    parameter  int NUM_STOCKS   = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int QTY_WIDTH    = 32,
    parameter  int FP_WORD_SIZE = 64,
    parameter  int MIN_GAP      = 16,
    localparam int SID_W        = $clog2(NUM_STOCKS)
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_quote_valid,
    input  logic [SID_W-1:0]        i_stock_id,
    input  logic [DATA_WIDTH-1:0]   i_buy_price,
    input  logic [DATA_WIDTH-1:0]   i_sell_price,
    input  logic [QTY_WIDTH-1:0]    i_quantity,
    input  logic [FP_WORD_SIZE-1:0] i_timestamp,
    input  logic                    i_flush,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic                    o_side,
    output logic [SID_W-1:0]        o_stock_id,
    output logic [DATA_WIDTH-1:0]   o_price,
    output logic [QTY_WIDTH-1:0]    o_quantity,
    output logic [FP_WORD_SIZE-1:0] o_timestamp,
    output logic [15:0]             o_coalesce_cnt,
    output logic                    o_busy
);

    localparam int               GAP_W    = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

    logic [DATA_WIDTH-1:0]   r_slot_buy  [NUM_STOCKS];
    logic [DATA_WIDTH-1:0]   r_slot_sell [NUM_STOCKS];
    logic [QTY_WIDTH-1:0]    r_slot_qty  [NUM_STOCKS];
    logic [FP_WORD_SIZE-1:0] r_slot_ts   [NUM_STOCKS];
    logic [GAP_W-1:0]        r_gap       [NUM_STOCKS];
    logic [NUM_STOCKS-1:0]   r_pending, r_elig;
    logic [NUM_STOCKS-1:0]   w_wr, w_take, w_elig_now, w_pending_next, w_req;

    egress_state_t           r_state;
    side_t                   r_side;
    logic [SID_W-1:0]        r_rr_ptr, r_stock;
    logic                    r_valid, r_busy;
    logic [DATA_WIDTH-1:0]   r_price, r_hold_sell;
    logic [QTY_WIDTH-1:0]    r_qty;
    logic [FP_WORD_SIZE-1:0] r_ts;
    logic [15:0]             r_coalesce_cnt;

    logic                    w_quote_ok, w_start, w_grant_vld, w_coalesce, w_busy_next;
    logic [SID_W-1:0]        w_grant_id;

    assign w_quote_ok  = i_quote_valid && !i_flush &&
                         ((i_buy_price != '0) || (i_sell_price != '0));
    // Eligibility must hold on the registered and the live view, so the registered
    // copy shortens the arbiter path while flush, grant and gap reloads act at once.
    assign w_req       = r_elig & w_elig_now;
    assign w_start     = (r_state == IDLE) && w_grant_vld && !i_flush;
    assign w_coalesce  = |(w_wr & r_pending & ~w_take);
    assign w_busy_next = (|w_pending_next) ||
                         ((r_state == IDLE) ? w_start : (r_state != DONE));

    for (genvar gi = 0; gi < NUM_STOCKS; gi++) begin : g_slot
        assign w_wr[gi]           = w_quote_ok && (i_stock_id == SID_W'(gi));
        assign w_take[gi]         = w_start && (w_grant_id == SID_W'(gi));
        assign w_elig_now[gi]     = r_pending[gi] && (r_gap[gi] == '0);
        assign w_pending_next[gi] = !i_flush && (w_wr[gi] || (r_pending[gi] && !w_take[gi]));
    end

    rr_arbiter #(.N(NUM_STOCKS)) u_rr_arbiter (
        .i_req       (w_req),
        .i_ptr       (r_rr_ptr),
        .o_grant_id  (w_grant_id),
        .o_grant_vld (w_grant_vld)
    );

    always_ff @(posedge i_clk) begin
        for (int s = 0; s < NUM_STOCKS; s++) begin
            if (w_wr[s]) begin
                r_slot_buy[s]  <= i_buy_price;
                r_slot_sell[s] <= i_sell_price;
                r_slot_qty[s]  <= i_quantity;
                r_slot_ts[s]   <= i_timestamp;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending      <= '0;
            r_elig         <= '0;
            r_busy         <= 1'b0;
            r_coalesce_cnt <= '0;
            for (int s = 0; s < NUM_STOCKS; s++) r_gap[s] <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_elig    <= w_elig_now;
            r_busy    <= w_busy_next;
            if (w_coalesce && (r_coalesce_cnt != 16'hFFFF))
                r_coalesce_cnt <= r_coalesce_cnt + 16'd1;
            for (int s = 0; s < NUM_STOCKS; s++) begin
                if ((r_state == DONE) && (r_stock == SID_W'(s)))
                    r_gap[s] <= GAP_LOAD;
                else if (r_gap[s] != '0)
                    r_gap[s] <= r_gap[s] - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_valid     <= 1'b0;
            r_side      <= SIDE_BUY;
            r_stock     <= '0;
            r_price     <= '0;
            r_qty       <= '0;
            r_ts        <= '0;
            r_hold_sell <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_rr_ptr    <= w_grant_id;
                    r_stock     <= w_grant_id;
                    r_qty       <= r_slot_qty[w_grant_id];
                    r_ts        <= r_slot_ts[w_grant_id];
                    r_hold_sell <= r_slot_sell[w_grant_id];
                    r_valid     <= 1'b1;
                    if (r_slot_buy[w_grant_id] != '0) begin
                        r_state <= BUY;
                        r_side  <= SIDE_BUY;
                        r_price <= r_slot_buy[w_grant_id];
                    end else begin
                        r_state <= SELL;
                        r_side  <= SIDE_SELL;
                        r_price <= r_slot_sell[w_grant_id];
                    end
                end
                BUY: if (i_ready) begin
                    if (r_hold_sell != '0) begin
                        r_state <= SELL;
                        r_side  <= SIDE_SELL;
                        r_price <= r_hold_sell;
                    end else begin
                        r_state <= DONE;
                        r_valid <= 1'b0;
                    end
                end
                SELL: if (i_ready) begin
                    r_state <= DONE;
                    r_valid <= 1'b0;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_valid        = r_valid;
    assign o_side         = r_side;
    assign o_stock_id     = r_stock;
    assign o_price        = r_price;
    assign o_quantity     = r_qty;
    assign o_timestamp    = r_ts;
    assign o_coalesce_cnt = r_coalesce_cnt;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_quote_egress_scheduler.sv
// Directed bench for quote_egress_scheduler: one throttled instance (MIN_GAP=16) and
// one unthrottled instance (MIN_GAP=0) share the same stimulus.
module tb_quote_egress_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        q_valid = 1'b0;
    logic [1:0]  q_id = '0;
    logic [31:0] q_buy = '0, q_sell = '0, q_qty = '0;
    logic [63:0] q_ts = '0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;

    logic        a_valid, a_side, a_busy;
    logic [1:0]  a_stock;
    logic [31:0] a_price, a_qty;
    logic [63:0] a_ts;
    logic [15:0] a_cnt;

    logic        b_valid, b_side, b_busy;
    logic [1:0]  b_stock;
    logic [31:0] b_price, b_qty;
    logic [63:0] b_ts;
    logic [15:0] b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    quote_egress_scheduler #(
        .NUM_STOCKS(4), .DATA_WIDTH(32), .QTY_WIDTH(32), .FP_WORD_SIZE(64), .MIN_GAP(16)
    ) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_quote_valid(q_valid), .i_stock_id(q_id),
        .i_buy_price(q_buy), .i_sell_price(q_sell), .i_quantity(q_qty), .i_timestamp(q_ts),
        .i_flush(flush), .i_ready(ready), .o_valid(a_valid), .o_side(a_side),
        .o_stock_id(a_stock), .o_price(a_price), .o_quantity(a_qty), .o_timestamp(a_ts),
        .o_coalesce_cnt(a_cnt), .o_busy(a_busy)
    );

    quote_egress_scheduler #(
        .NUM_STOCKS(4), .DATA_WIDTH(32), .QTY_WIDTH(32), .FP_WORD_SIZE(64), .MIN_GAP(0)
    ) u_dut_nogap (
        .i_clk(clk), .i_reset_n(rst_n), .i_quote_valid(q_valid), .i_stock_id(q_id),
        .i_buy_price(q_buy), .i_sell_price(q_sell), .i_quantity(q_qty), .i_timestamp(q_ts),
        .i_flush(flush), .i_ready(ready), .o_valid(b_valid), .o_side(b_side),
        .o_stock_id(b_stock), .o_price(b_price), .o_quantity(b_qty), .o_timestamp(b_ts),
        .o_coalesce_cnt(b_cnt), .o_busy(b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_quote(input logic [1:0] id, input logic [31:0] buy, input logic [31:0] sell,
                             input logic [31:0] qty, input logic [63:0] ts);
        q_valid = 1'b1; q_id = id; q_buy = buy; q_sell = sell; q_qty = qty; q_ts = ts;
    endtask

    task automatic do_reset();
        q_valid = 1'b0; flush = 1'b0; ready = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({a_valid, a_side, a_stock, a_price, a_qty, a_ts, a_cnt, a_busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b price=%0d cnt=%0d busy=%b, expected all zero",
                     a_valid, a_price, a_cnt, a_busy);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_reset();
        ready = 1'b1;
        put_quote(2'd2, 32'd100, 32'd105, 32'd10, 64'h1122_3344_5566_7788);
        step();
        q_valid = 1'b0;
        n_checks++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", a_busy); end
        n_checks++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_n: got valid %b expected 0", a_valid); end
        step();
        n_checks++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_n1: got valid %b expected 0", a_valid); end
        step();
        $display("beat stk=%0d side=%0d price=%0d", a_stock, a_side, a_price);
        n_checks++;
        if ({a_valid, a_side, a_stock, a_price, a_qty, a_ts} !==
            {1'b1, 1'b0, 2'd2, 32'd100, 32'd10, 64'h1122_3344_5566_7788}) begin
            n_fail++;
            $display("FAIL basic_buy: got v=%b s=%b stk=%0d p=%0d q=%0d ts=%h expected 1 0 2 100 10 1122334455667788",
                     a_valid, a_side, a_stock, a_price, a_qty, a_ts);
        end
        step();
        $display("beat stk=%0d side=%0d price=%0d", a_stock, a_side, a_price);
        n_checks++;
        if ({a_valid, a_side, a_stock, a_price, a_qty} !== {1'b1, 1'b1, 2'd2, 32'd105, 32'd10}) begin
            n_fail++;
            $display("FAIL basic_sell: got v=%b s=%b stk=%0d p=%0d q=%0d expected 1 1 2 105 10",
                     a_valid, a_side, a_stock, a_price, a_qty);
        end
        step();
        n_checks++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid: got %b expected 0", a_valid); end
        step();
        n_checks++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy: got %b expected 0", a_busy); end
    endtask

    task automatic test_coalesce();
        int          nb;
        logic [31:0] got_price [8];
        logic [1:0]  got_stk [8];
        logic [31:0] exp_price [4] = '{32'd10, 32'd11, 32'd200, 32'd201};
        logic [1:0]  exp_stk [4]   = '{2'd0, 2'd0, 2'd1, 2'd1};
        nb = 0;
        do_reset();
        put_quote(2'd0, 32'd10, 32'd11, 32'd1, 64'd1);
        step();
        q_valid = 1'b0;
        step(); step();
        n_checks++;
        if (a_valid !== 1'b1 || a_stock !== 2'd0) begin
            n_fail++; $display("FAIL coal_block: got v=%b stk=%0d expected 1 0", a_valid, a_stock);
        end
        put_quote(2'd1, 32'd150, 32'd151, 32'd2, 64'd2);
        step();
        put_quote(2'd1, 32'd200, 32'd201, 32'd3, 64'd3);
        step();
        q_valid = 1'b0;
        n_checks++;
        if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL coal_cnt: got %0d expected 1", a_cnt); end
        ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (a_valid && nb < 8) begin
                $display("beat stk=%0d side=%0d price=%0d", a_stock, a_side, a_price);
                got_price[nb] = a_price; got_stk[nb] = a_stock; nb++;
            end
            step();
        end
        n_checks++;
        if (nb != 4) begin n_fail++; $display("FAIL coal_nbeats: got %0d expected 4", nb); end
        for (int i = 0; i < 4 && i < nb; i++) begin
            n_checks++;
            if (got_price[i] !== exp_price[i] || got_stk[i] !== exp_stk[i]) begin
                n_fail++;
                $display("FAIL coal_beat%0d: got stk=%0d p=%0d expected stk=%0d p=%0d",
                         i, got_stk[i], got_price[i], exp_stk[i], exp_price[i]);
            end
        end
        n_checks++;
        if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL coal_cnt_final: got %0d expected 1", a_cnt); end
    endtask

    task automatic test_round_robin();
        int          nb;
        logic        requoted;
        logic [31:0] got_price [12];
        logic [1:0]  got_stk [12];
        logic [1:0]  exp_stk [10]   = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
        logic [31:0] exp_price [10] = '{32'd10, 32'd11, 32'd20, 32'd21, 32'd30,
                                        32'd31, 32'd40, 32'd41, 32'd50, 32'd51};
        nb = 0;
        requoted = 1'b0;
        do_reset();
        put_quote(2'd3, 32'd10, 32'd11, 32'd7, 64'd7);
        step();
        q_valid = 1'b0;
        step(); step();
        n_checks++;
        if (b_valid !== 1'b1 || b_stock !== 2'd3) begin
            n_fail++; $display("FAIL rr_first: got v=%b stk=%0d expected 1 3", b_valid, b_stock);
        end
        put_quote(2'd0, 32'd20, 32'd21, 32'd7, 64'd7); step();
        put_quote(2'd1, 32'd30, 32'd31, 32'd7, 64'd7); step();
        put_quote(2'd3, 32'd40, 32'd41, 32'd7, 64'd7); step();
        q_valid = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            q_valid = 1'b0;
            if (b_valid && nb < 12) begin
                $display("beat stk=%0d side=%0d price=%0d", b_stock, b_side, b_price);
                got_price[nb] = b_price; got_stk[nb] = b_stock; nb++;
                if (!requoted && b_stock == 2'd0 && b_side == 1'b0) begin
                    put_quote(2'd0, 32'd50, 32'd51, 32'd7, 64'd7);
                    requoted = 1'b1;
                end
            end
            step();
        end
        n_checks++;
        if (nb != 10) begin n_fail++; $display("FAIL rr_nbeats: got %0d expected 10", nb); end
        for (int i = 0; i < 10 && i < nb; i++) begin
            n_checks++;
            if (got_stk[i] !== exp_stk[i] || got_price[i] !== exp_price[i]) begin
                n_fail++;
                $display("FAIL rr_beat%0d: got stk=%0d p=%0d expected stk=%0d p=%0d",
                         i, got_stk[i], got_price[i], exp_stk[i], exp_price[i]);
            end
        end
    endtask

    task automatic test_min_gap();
        logic        found;
        int          ka, kb;
        logic [31:0] pa;
        found = 1'b0; ka = -1; kb = -1; pa = '0;
        do_reset();
        ready = 1'b1;
        put_quote(2'd0, 32'd1, 32'd2, 32'd9, 64'd9);
        step();
        q_valid = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (a_valid && a_side) found = 1'b1;
            else step();
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL gap_sell_timeout: got no sell beat expected one"); end
        put_quote(2'd0, 32'd3, 32'd4, 32'd9, 64'd9);
        step();
        q_valid = 1'b0;
        step();
        for (int k = 1; k <= 30; k++) begin
            step();
            if (ka < 0 && a_valid) begin ka = k; pa = a_price; end
            if (kb < 0 && b_valid) kb = k;
        end
        $display("requote stk0 beat after %0d cycles (MIN_GAP=16), %0d cycles (MIN_GAP=0)", ka, kb);
        n_checks++;
        if (ka < 16) begin n_fail++; $display("FAIL gap_throttle: got beat after %0d cycles expected >=16", ka); end
        n_checks++;
        if (pa !== 32'd3) begin n_fail++; $display("FAIL gap_price: got %0d expected 3", pa); end
        n_checks++;
        if (kb < 1 || kb >= 16) begin n_fail++; $display("FAIL gap_zero: got beat after %0d cycles expected 1..15", kb); end
    endtask

    task automatic test_stall();
        do_reset();
        put_quote(2'd1, 32'd70, 32'd71, 32'd5, 64'd99);
        step();
        q_valid = 1'b0;
        for (int c = 0; c < 6 && !a_valid; c++) step();
        n_checks++;
        if (a_valid !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: got valid %b expected 1", a_valid); end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({a_valid, a_side, a_stock, a_price, a_qty, a_ts} !==
                {1'b1, 1'b0, 2'd1, 32'd70, 32'd5, 64'd99}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b s=%b stk=%0d p=%0d q=%0d ts=%0d expected 1 0 1 70 5 99",
                         c, a_valid, a_side, a_stock, a_price, a_qty, a_ts);
            end
            step();
        end
        ready = 1'b1;
        step();
        n_checks++;
        if ({a_valid, a_side, a_price} !== {1'b1, 1'b1, 32'd71}) begin
            n_fail++; $display("FAIL stall_sell: got v=%b s=%b p=%0d expected 1 1 71", a_valid, a_side, a_price);
        end
        step();
        n_checks++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end: got valid %b expected 0", a_valid); end
    endtask

    task automatic test_sides();
        logic seen;
        seen = 1'b0;
        do_reset();
        ready = 1'b1;
        put_quote(2'd2, 32'd0, 32'd50, 32'd4, 64'd4);
        step();
        q_valid = 1'b0;
        step(); step();
        n_checks++;
        if ({a_valid, a_side, a_stock, a_price} !== {1'b1, 1'b1, 2'd2, 32'd50}) begin
            n_fail++; $display("FAIL sell_only: got v=%b s=%b stk=%0d p=%0d expected 1 1 2 50",
                               a_valid, a_side, a_stock, a_price);
        end
        step();
        n_checks++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL sell_only_end: got valid %b expected 0", a_valid); end
        put_quote(2'd3, 32'd0, 32'd0, 32'd4, 64'd4);
        step();
        q_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (a_valid) seen = 1'b1;
            step();
        end
        n_checks++;
        if (seen !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_quote: got beat=%b busy=%b expected 0 0", seen, a_busy);
        end
    endtask

    task automatic test_flush();
        int          nb;
        logic [31:0] got_price [8];
        nb = 0;
        do_reset();
        put_quote(2'd2, 32'd60, 32'd61, 32'd6, 64'd6);
        step();
        q_valid = 1'b0;
        step(); step();
        n_checks++;
        if (a_valid !== 1'b1 || a_stock !== 2'd2) begin
            n_fail++; $display("FAIL flush_inflight: got v=%b stk=%0d expected 1 2", a_valid, a_stock);
        end
        put_quote(2'd0, 32'd80, 32'd81, 32'd6, 64'd6); step();
        put_quote(2'd1, 32'd90, 32'd91, 32'd6, 64'd6); step();
        put_quote(2'd3, 32'd95, 32'd96, 32'd6, 64'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        q_valid = 1'b0;
        n_checks++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy: got %b expected 1", a_busy); end
        ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (a_valid && nb < 8) begin
                $display("beat stk=%0d side=%0d price=%0d", a_stock, a_side, a_price);
                got_price[nb] = a_price; nb++;
            end
            step();
        end
        n_checks++;
        if (nb != 2) begin n_fail++; $display("FAIL flush_nbeats: got %0d expected 2", nb); end
        n_checks++;
        if (nb >= 2 && (got_price[0] !== 32'd60 || got_price[1] !== 32'd61)) begin
            n_fail++; $display("FAIL flush_prices: got %0d %0d expected 60 61", got_price[0], got_price[1]);
        end
        n_checks++;
        if (a_busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got busy %b expected 0", a_busy); end
    endtask

    task automatic test_reset_in_sell();
        do_reset();
        ready = 1'b1;
        put_quote(2'd1, 32'd5, 32'd6, 32'd3, 64'd3);
        step();
        q_valid = 1'b0;
        step(); step(); step();
        n_checks++;
        if (a_valid !== 1'b1 || a_side !== 1'b1) begin
            n_fail++; $display("FAIL rst_sell_setup: got v=%b s=%b expected 1 1", a_valid, a_side);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_price !== 32'd0) begin
            n_fail++; $display("FAIL rst_sell_async: got v=%b busy=%b p=%0d expected 0 0 0", a_valid, a_busy, a_price);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coalesce();
        test_round_robin();
        test_min_gap();
        test_stall();
        test_sides();
        test_flush();
        test_reset_in_sell();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the end of test");
        $fatal(1, "watchdog");
    end

endmodule
